// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter for the integer register file: in-order pipeline writeback
// versus buffered multi-cycle results, with a per-register pending scoreboard.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_wb_addr,
    input  logic [31:0] pipe_wb_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_rd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        rf_en,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        wb_stall,
    output logic [31:0] pending
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] starve_cnt;
    logic [31:0]   pending_next;
    logic          empty, full, push, pop, grant_pipe, starve_hit;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign mc_ready   = !full;
    assign push       = mc_valid && !full;
    // The stall cycle exists to give the FIFO head the port, so it masks the pipeline.
    assign grant_pipe = !wb_stall && pipe_wb_en;
    assign pop        = !grant_pipe && !empty;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign starve_hit = !empty && !pop && (starve_cnt == CW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mc_addr;
            fifo_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            wb_stall <= starve_hit;
            if (empty || pop || starve_hit) starve_cnt <= '0;
            else                             starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Set after clear so a same-cycle issue to the popped register stays pending.
    always_comb begin
        pending_next = pending;
        if (pop)      pending_next[head_addr]   = 1'b0;
        if (mc_issue) pending_next[mc_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (grant_pipe) begin
            rf_en <= (pipe_wb_addr != 5'd0);
            rf_wa <= pipe_wb_addr;
            rf_wd <= pipe_wb_data;
        end else if (pop) begin
            rf_en <= (head_addr != 5'd0);
            rf_wa <= head_addr;
            rf_wd <= head_data;
        end else begin
            rf_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: behavioural model feeds an expected-write queue,
// compared against the registered write port one cycle after each edge.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        rf_en;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        wb_stall;
    logic [31:0] pending;

    regfile_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_en(pipe_wb_en), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
        .rf_en(rf_en), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .wb_stall(wb_stall), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    typedef struct { logic en; logic [4:0] wa; logic [31:0] wd; } exp_t;

    ent_t  mq[$];
    exp_t  exp_q[$];
    logic  m_stall;
    int    m_cnt;
    logic [31:0] m_pend;
    bit    last_push, last_gp;
    int    pc;
    int    checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); exp_q.delete();
        m_stall = 1'b0; m_cnt = 0; m_pend = '0;
    endtask

    task automatic idle();
        pipe_wb_en = 1'b0; mc_issue = 1'b0; mc_valid = 1'b0;
        pipe_wb_addr = '0; pipe_wb_data = '0; mc_issue_rd = '0; mc_addr = '0; mc_data = '0;
    endtask

    // Pipeline source: a new write only after the previous one was accepted.
    task automatic pipe_next();
        pipe_wb_en = 1'b1;
        if (last_gp) begin
            pc++;
            pipe_wb_addr = 5'(16 + (pc % 8));
            pipe_wb_data = 32'hC000_0000 + 32'(pc);
        end
    endtask

    // One clock: check state, predict the write, clock, compare the write port.
    task automatic cyc();
        exp_t e;
        ent_t h;
        bit gp, dpop, dpush, nstall;
        logic [31:0] np;
        chk("mc_ready", 32'(mc_ready), 32'(mq.size() < 4));
        chk("wb_stall", 32'(wb_stall), 32'(m_stall));
        chk("pending", pending, m_pend);
        gp    = !m_stall && pipe_wb_en;
        dpop  = !gp && (mq.size() > 0);
        dpush = mc_valid && (mq.size() < 4);
        e.en = 1'b0; e.wa = '0; e.wd = '0;
        if (gp) begin
            e.en = (pipe_wb_addr != 0); e.wa = pipe_wb_addr; e.wd = pipe_wb_data;
        end else if (dpop) begin
            h = mq[0];
            e.en = (h.a != 0); e.wa = h.a; e.wd = h.d;
        end
        exp_q.push_back(e);
        np = m_pend;
        if (dpop) np[mq[0].a] = 1'b0;
        if (mc_issue) np[mc_issue_rd] = 1'b1;
        np[0] = 1'b0;
        nstall = 1'b0;
        if (mq.size() == 0 || dpop) m_cnt = 0;
        else if (m_cnt + 1 == 8) begin m_cnt = 0; nstall = 1'b1; end
        else m_cnt++;
        if (dpop) void'(mq.pop_front());
        if (dpush) begin h.a = mc_addr; h.d = mc_data; mq.push_back(h); end
        last_push = dpush;
        last_gp   = gp;
        @(posedge clk); #1;
        m_pend = np; m_stall = nstall;
        e = exp_q.pop_front();
        chk("rf_en", 32'(rf_en), 32'(e.en));
        if (e.en) begin
            chk("rf_wa", 32'(rf_wa), 32'(e.wa));
            chk("rf_wd", rf_wd, e.wd);
        end
    endtask

    initial begin
        int n;
        logic [31:0] held;
        idle();
        rst_n = 1'b0;
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1; pipe_wb_data = 32'h11;
        mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h44;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rf_en", 32'(rf_en), 0);
        chk("rst_pending", pending, 0);
        chk("rst_mc_ready", 32'(mc_ready), 1);
        chk("rst_wb_stall", 32'(wb_stall), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; mc_valid = 1'b0;
        cyc();
        chk("first_grant_wa", 32'(rf_wa), 1);

        // Pipeline only, then a write to x0
        pipe_wb_addr = 5'd5; pipe_wb_data = 32'hDEADBEEF;
        cyc();
        chk("pipe_wd", rf_wd, 32'hDEADBEEF);
        pipe_wb_addr = 5'd0; pipe_wb_data = 32'h5555;
        cyc();
        chk("pipe_x0_en", 32'(rf_en), 0);

        // Multi-cycle path
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd7;
        cyc();
        chk("mc_pend_set", 32'(pending[7]), 1);
        idle(); mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h1234;
        cyc();
        chk("mc_push_no_wr", 32'(rf_en), 0);
        idle();
        cyc();
        chk("mc_pop_wd", rf_wd, 32'h1234);
        chk("mc_pend_clr", 32'(pending[7]), 0);

        // Full FIFO with a busy pipeline; fifth result must be held off, not lost
        last_gp = 1'b1; pc = 0;
        for (int k = 0; k < 5; k++) begin
            idle(); pipe_next(); mc_issue = 1'b1; mc_issue_rd = 5'(10 + k);
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                idle(); pipe_next();
                mc_valid = 1'b1; mc_addr = 5'(10 + k); mc_data = 32'hA000 + 32'(k);
                cyc(); n++;
            end while (!last_push && n < 40);
            if (!last_push) chk("push_timeout", 0, 1);
            if (k == 3) chk("full_mc_ready", 32'(mc_ready), 0);
        end
        idle();
        n = 0;
        while (mq.size() > 0 && n < 20) begin cyc(); n++; end
        cyc();
        chk("drain_empty", 32'(mq.size()), 0);
        chk("drain_pending", pending, 0);

        // Starvation with one buffered entry
        idle(); pipe_next(); mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99;
        cyc();
        mc_valid = 1'b0;
        n = 0;
        while (!wb_stall && n < 20) begin pipe_next(); cyc(); n++; end
        chk("starve_wait", 32'(n), 8);
        pipe_next(); held = pipe_wb_data;
        cyc();
        chk("stall_head_wa", 32'(rf_wa), 9);
        chk("stall_one_cycle", 32'(wb_stall), 0);
        pipe_next();
        chk("held_stable", pipe_wb_data, held);
        cyc();
        chk("held_written", rf_wd, held);

        // Same-cycle issue and pop on x3: set wins
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd3;
        cyc();
        idle(); mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h33;
        cyc();
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd3;
        cyc();
        chk("collide_pend3", 32'(pending[3]), 1);
        chk("collide_wd", rf_wd, 32'h33);

        // Mid-operation reset with three buffered results
        for (int k = 0; k < 3; k++) begin
            idle(); pipe_next(); mc_issue = 1'b1; mc_issue_rd = 5'(12 + k);
            mc_valid = 1'b1; mc_addr = 5'(12 + k); mc_data = 32'hB000 + 32'(k);
            cyc();
        end
        chk("pre_rst_count", 32'(mq.size()), 3);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("mid_rst_rf_en", 32'(rf_en), 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_mc_ready", 32'(mc_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        repeat (3) cyc();
        chk("post_rst_no_wr", 32'(rf_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
